// File: rtl/otter_csr_int_if.sv
// Bus between the OTTER control path and the machine-mode CSR / interrupt block.
// The controller side drives requests; the CSR block answers with read data and interrupt flags.
interface otter_csr_int_if;
    logic        CSR_INT_IN;
    logic        CSR_intCLR;
    logic        CSR_intTaken;
    logic        CSR_WE;
    logic        CSR_MRET;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_WD;
    logic [31:0] CSR_PC;
    logic [31:0] CSR_RD;
    logic [31:0] CSR_MTVEC;
    logic [31:0] CSR_MEPC;
    logic        CSR_INT;
    logic        CSR_prevINT;

    modport master (
        output CSR_INT_IN, CSR_intCLR, CSR_intTaken, CSR_WE, CSR_MRET,
        output CSR_ADDR, CSR_WD, CSR_PC,
        input  CSR_RD, CSR_MTVEC, CSR_MEPC, CSR_INT, CSR_prevINT
    );

    modport slave (
        input  CSR_INT_IN, CSR_intCLR, CSR_intTaken, CSR_WE, CSR_MRET,
        input  CSR_ADDR, CSR_WD, CSR_PC,
        output CSR_RD, CSR_MTVEC, CSR_MEPC, CSR_INT, CSR_prevINT
    );
endinterface

// File: rtl/otter_csr_int.sv
// Machine-mode CSR file (mstatus, mtvec, mepc, mcause) and interrupt gating/pending latch
// for the multicycle OTTER core.
module otter_csr_int #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic            CSR_CLK,
    input logic            CSR_RESET,
    otter_csr_int_if.slave bus
);
    localparam logic [11:0] AddrMstatus = 12'h300;
    localparam logic [11:0] AddrMtvec   = 12'h305;
    localparam logic [11:0] AddrMepc    = 12'h341;
    localparam logic [11:0] AddrMcause  = 12'h342;
    localparam logic [31:0] CauseExtInt = 32'h8000_000B;

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        pend_q, pend_d;
    logic        int_req;

    assign int_req = bus.CSR_INT_IN & mie_q;

    // Later assignments override earlier ones: intTaken > MRET > software write.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;

        if (bus.CSR_WE) begin
            case (bus.CSR_ADDR)
                AddrMstatus: begin
                    mie_d  = bus.CSR_WD[3];
                    mpie_d = bus.CSR_WD[7];
                end
                AddrMtvec:  mtvec_d  = {bus.CSR_WD[31:2], 2'b00};
                AddrMepc:   mepc_d   = {bus.CSR_WD[31:2], 2'b00};
                AddrMcause: mcause_d = bus.CSR_WD;
                default: ;
            endcase
        end

        if (bus.CSR_MRET) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (bus.CSR_intTaken) begin
            mepc_d   = bus.CSR_PC;
            mcause_d = CauseExtInt;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
    end

    // An interrupt coinciding with the clear is not latched; the FSM sees CSR_INT directly.
    always_comb begin
        pend_d = pend_q;
        if (bus.CSR_intCLR) begin
            pend_d = 1'b0;
        end else if (int_req) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge CSR_CLK) begin
        if (CSR_RESET) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= {MTVEC_RESET[31:2], 2'b00};
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
            pend_q   <= 1'b0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        bus.CSR_RD = 32'h0;
        case (bus.CSR_ADDR)
            AddrMstatus: bus.CSR_RD = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            AddrMtvec:   bus.CSR_RD = mtvec_q;
            AddrMepc:    bus.CSR_RD = mepc_q;
            AddrMcause:  bus.CSR_RD = mcause_q;
            default: ;
        endcase
    end

    assign bus.CSR_MTVEC   = mtvec_q;
    assign bus.CSR_MEPC    = mepc_q;
    assign bus.CSR_INT     = int_req;
    assign bus.CSR_prevINT = pend_q;
endmodule
